// File: rtl/lcd_de_receiver.sv
// -----------------------------------------------------------------------------
// lcd_de_receiver
//   DE-only LCD video receiver. Recovers pixel coordinates from the data-enable
//   strobe alone: a long DE-low run marks vertical blank, every DE-low edge
//   after active pixels ends a line. Emits registered pixels with coordinates,
//   frame/line qualifiers, a per-frame XOR checksum and sticky length errors.
//
// Ports
//   i_clk, i_rst_n        pixel clock, asynchronous active-low reset
//   i_data_enable         DE, high = valid pixel this cycle
//   i_red/green/blue      pixel colour
//   i_err_clr             synchronous clear of sticky error flags
//   o_pix_valid           registered pixel strobe (1-cycle latency)
//   o_pixel               {red, green, blue} of emitted pixel
//   o_col, o_row          coordinates of emitted pixel
//   o_frame_start         emitted pixel is col 0 / row 0
//   o_line_end            emitted pixel is col H_ACTIVE-1
//   o_frame_done          one-cycle pulse after a vblank closing a frame
//   o_frame_sum           XOR checksum of the previous frame
//   o_frame_cnt           completed-frame count (wraps)
//   o_err_hlen/o_err_vlen sticky line / frame length errors
//   o_locked              last closed frame had no length error
//
// state   | meaning
// --------+-------------------------------------------------------------
// SYNC    | after reset, waiting for the first vblank; DE ignored
// BLANK   | between lines or in vertical blank
// ACTIVE  | inside a DE-high run (a line)
// -----------------------------------------------------------------------------
module lcd_de_receiver #(
  parameter int H_ACTIVE      = 480,
  parameter int V_ACTIVE      = 272,
  parameter int VBLANK_THRESH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_data_enable,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  input  logic        i_err_clr,
  output logic        o_pix_valid,
  output logic [23:0] o_pixel,
  output logic [8:0]  o_col,
  output logic [8:0]  o_row,
  output logic        o_frame_start,
  output logic        o_line_end,
  output logic        o_frame_done,
  output logic [23:0] o_frame_sum,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_hlen,
  output logic        o_err_vlen,
  output logic        o_locked
);

  localparam int             GW      = $clog2(VBLANK_THRESH + 1);
  localparam logic [GW-1:0]  GAP_MAX = GW'(VBLANK_THRESH);
  localparam logic [GW-1:0]  GAP_PRE = GW'(VBLANK_THRESH - 1);
  localparam logic [15:0]    H_LIM   = 16'(H_ACTIVE);
  localparam logic [15:0]    V_LIM   = 16'(V_ACTIVE);
  localparam logic [15:0]    CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t       r_state;
  logic [GW-1:0] r_gap;
  logic [15:0]  r_col;
  logic [15:0]  r_row;
  logic [23:0]  r_acc;
  logic         r_frame_err;

  logic         r_pix_valid;
  logic [23:0]  r_pixel;
  logic [8:0]   r_col_out;
  logic [8:0]   r_row_out;
  logic         r_frame_start;
  logic         r_line_end;
  logic         r_frame_done;
  logic [23:0]  r_frame_sum;
  logic [15:0]  r_frame_cnt;
  logic         r_err_hlen;
  logic         r_err_vlen;
  logic         r_locked;

  logic         w_vblank;
  logic [15:0]  w_col_cur;
  logic         w_emit;
  logic [23:0]  w_pixel;
  logic         w_line_done;
  logic         w_hlen_bad;
  logic         w_close;
  logic         w_vlen_bad;

  // Vblank fires only on the cycle the gap counter steps onto the threshold;
  // once saturated it stays there, so one long gap gives one event. A DE-high
  // cycle clears the counter instead, which suppresses a would-be event.
  assign w_vblank    = !i_data_enable && (r_gap == GAP_PRE);
  // The first pixel of a line arrives while still in BLANK and is column 0.
  assign w_col_cur   = (r_state == S_ACTIVE) ? r_col : 16'd0;
  assign w_emit      = i_data_enable && (r_state != S_SYNC) &&
                       (w_col_cur < H_LIM) && (r_row < V_LIM);
  assign w_pixel     = {i_red, i_green, i_blue};
  assign w_line_done = (r_state == S_ACTIVE) && !i_data_enable;
  assign w_hlen_bad  = w_line_done && (r_col != H_LIM);
  assign w_close     = w_vblank && (r_state == S_BLANK);
  assign w_vlen_bad  = w_close && (r_row != V_LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_SYNC;
      r_gap         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_acc         <= '0;
      r_frame_err   <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pixel       <= '0;
      r_col_out     <= '0;
      r_row_out     <= '0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_sum   <= '0;
      r_frame_cnt   <= '0;
      r_err_hlen    <= 1'b0;
      r_err_vlen    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      if (i_data_enable)
        r_gap <= '0;
      else if (r_gap != GAP_MAX)
        r_gap <= r_gap + 1'b1;

      r_pix_valid <= w_emit;
      if (w_emit) begin
        r_pixel       <= w_pixel;
        r_col_out     <= w_col_cur[8:0];
        r_row_out     <= r_row[8:0];
        r_frame_start <= (w_col_cur == 16'd0) && (r_row == 16'd0);
        r_line_end    <= (w_col_cur == H_LIM - 16'd1);
      end else begin
        r_frame_start <= 1'b0;
        r_line_end    <= 1'b0;
      end

      if (w_close)
        r_acc <= '0;
      else if (w_emit)
        r_acc <= r_acc ^ w_pixel;

      r_frame_done <= w_close;
      if (w_close) begin
        r_frame_sum <= r_acc;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_locked    <= !(r_frame_err || w_vlen_bad);
        r_frame_err <= 1'b0;
      end else if (w_hlen_bad) begin
        r_frame_err <= 1'b1;
      end

      // Set has priority over a simultaneous clear.
      if (w_hlen_bad)
        r_err_hlen <= 1'b1;
      else if (i_err_clr)
        r_err_hlen <= 1'b0;

      if (w_vlen_bad)
        r_err_vlen <= 1'b1;
      else if (i_err_clr)
        r_err_vlen <= 1'b0;

      case (r_state)
        S_SYNC: begin
          if (w_vblank)
            r_state <= S_BLANK;
        end
        S_BLANK: begin
          if (i_data_enable) begin
            r_state <= S_ACTIVE;
            r_col   <= 16'd1;
          end
        end
        S_ACTIVE: begin
          if (!i_data_enable) begin
            r_state <= S_BLANK;
            if (r_row != CNT_MAX)
              r_row <= r_row + 16'd1;
          end else if (r_col != CNT_MAX) begin
            r_col <= r_col + 16'd1;
          end
        end
        default: r_state <= S_SYNC;
      endcase

      if (w_vblank)
        r_row <= '0;
    end
  end

  assign o_pix_valid   = r_pix_valid;
  assign o_pixel       = r_pixel;
  assign o_col         = r_col_out;
  assign o_row         = r_row_out;
  assign o_frame_start = r_frame_start;
  assign o_line_end    = r_line_end;
  assign o_frame_done  = r_frame_done;
  assign o_frame_sum   = r_frame_sum;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_hlen    = r_err_hlen;
  assign o_err_vlen    = r_err_vlen;
  assign o_locked      = r_locked;

endmodule
